// File: rtl/wide_arith_pkg.sv
// Shared definitions for the wide-arithmetic datapath blocks.
// Provides the sequencer state encoding and the ceil-divide helper
// used to size slice counts at elaboration time.
package wide_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of d-sized pieces needed to cover n items.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/wide_sub_seq_sub_slice.sv
// Combinational W-bit subtract with borrow-in/borrow-out.
// Ports: a_i, b_i, borrow_i -> diff_o = a_i - b_i - borrow_i, borrow_o set on underflow.
// Zero latency, no flow control (pure function of its inputs).
module sub_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] ext;

    // One extra bit catches the underflow: it reads 1 whenever the
    // true result is negative, which is exactly the borrow out.
    always_comb begin
        ext      = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
        diff_o   = ext[W-1:0];
        borrow_o = ext[W];
    end

endmodule

// File: rtl/wide_sub_seq.sv
// Sequential wide subtractor: diff = a - b, one CHUNK-bit slice per clock, LSB first.
// Ports: in_valid/in_ready accept a,b; out_valid/out_ready present diff, borrow, zero, ones.
// Latency NCHUNK+1 clocks; no overlap, result held in DONE until out_ready.
module wide_sub_seq #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ones
);

    import wide_arith_pkg::*;

    localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0]    KLAST     = KW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LASTW);

    state_e            state_q;
    logic [PADW-1:0]   a_q;
    logic [PADW-1:0]   b_q;
    logic [PADW-1:0]   diff_q;
    logic [PADW-1:0]   diff_d;
    logic              bchain_q;
    logic [KW-1:0]     k_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              borrow_q;

    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK-1:0]  d_sl;
    logic [CHUNK-1:0]  d_sl_m;
    logic              bout;

    sub_slice #(.W(CHUNK)) u_slice (
        .a_i      (a_sl),
        .b_i      (b_sl),
        .borrow_i (bchain_q),
        .diff_o   (d_sl),
        .borrow_o (bout)
    );

    // Operands are stored zero-padded to a whole number of slices. With
    // both pads at zero, a borrow leaving bit WIDTH-1 ripples straight
    // through the pad, so the slice borrow-out equals the borrow at bit
    // WIDTH. The pad bits of the difference are masked to keep them zero.
    always_comb begin
        a_sl   = a_q[int'(k_q) * CHUNK +: CHUNK];
        b_sl   = b_q[int'(k_q) * CHUNK +: CHUNK];
        d_sl_m = (k_q == KLAST) ? (d_sl & LAST_MASK) : d_sl;
        diff_d = diff_q;
        diff_d[int'(k_q) * CHUNK +: CHUNK] = d_sl_m;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bchain_q    <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= PADW'(a);
                        b_q        <= PADW'(b);
                        bchain_q   <= 1'b0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_d;
                    bchain_q <= bout;
                    if (k_q == KLAST) begin
                        borrow_q    <= bout;
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q[WIDTH-1:0];
    assign borrow    = borrow_q;
    // Pad bits of diff_q are always zero, so the full-register NOR is exact.
    assign zero      = ~|diff_q;
    assign ones      = &diff_q[WIDTH-1:0];

endmodule

// File: tb/tb_wide_sub_seq.sv
module tb_wide_sub_seq;

    localparam int W = 100;
    localparam int C = 16;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ones;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         z;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wide_sub_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ones      (ones)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.br = (av < bv);
        e.z  = (e.d == '0);
        e.o  = (e.d == {W{1'b1}});
        sb.push_back(e);
    endtask

    // Offer one operand pair and hold it until the accept edge.
    task automatic send(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        push_exp(av, bv);
        tick();
        in_valid = 1'b0;
        chk({tag, "_accepted"}, W'(in_ready), W'(0));
    endtask

    // Called in the cycle right after the accept edge.
    task automatic collect(input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, W'(cyc), W'(LAT));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, W'(sb.size()), W'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_diff"},   diff,       e.d);
            chk({tag, "_borrow"}, W'(borrow), W'(e.br));
            chk({tag, "_zero"},   W'(zero),   W'(e.z));
            chk({tag, "_ones"},   W'(ones),   W'(e.o));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_clr"}, W'(out_valid), W'(0));
        chk({tag, "_ir_set"}, W'(in_ready),  W'(1));
    endtask

    initial begin
        logic [W-1:0] hold_d;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("rst_in_ready",  W'(in_ready),  W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_diff",      diff,          '0);
        chk("rst_borrow",    W'(borrow),    W'(0));
        chk("rst_zero",      W'(zero),      W'(1));
        chk("rst_ones",      W'(ones),      W'(0));
        rst_n = 1'b1;
        tick();

        send("t1", W'(3), W'(2));
        collect("t1");
        release_out("t1");

        send("t2", W'(1), W'(2));
        collect("t2");
        release_out("t2");

        send("t3", W'(1) << 64, W'(1));
        collect("t3");
        chk("t3_value", diff, W'(64'hffff_ffff_ffff_ffff));
        release_out("t3");

        send("t4", 100'hf00d_0000_0000_0000_beef, 100'hf00d_0000_0000_0000_beef);
        collect("t4");
        release_out("t4");

        // Hold the result for 5 cycles while a new op is offered.
        send("t5", W'(5), W'(9));
        collect("t5");
        hold_d   = diff;
        a        = W'(9);
        b        = W'(1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_diff", diff,          hold_d);
            chk("t5_hold_ov",   W'(out_valid), W'(1));
            chk("t5_hold_ir",   W'(in_ready),  W'(0));
            chk("t5_hold_brw",  W'(borrow),    W'(1));
        end
        in_valid = 1'b0;
        release_out("t5");
        send("t5b", W'(7), W'(7));
        collect("t5b");
        chk("t5b_zero", W'(zero), W'(1));
        release_out("t5b");

        // Abort an op in its third BUSY cycle.
        send("t6", W'(100'h123), W'(100'h45));
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_ov",   W'(out_valid), W'(0));
        chk("t6_ir",   W'(in_ready),  W'(1));
        chk("t6_diff", diff,          '0);
        chk("t6_zero", W'(zero),      W'(1));
        rst_n = 1'b1;
        void'(sb.pop_back());
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("t6_no_result", W'(seen), W'(0));

        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            send("rnd", ra, rb);
            collect("rnd");
            release_out("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
